// File: rtl/mbed_serial_rx_multi.sv
// mbed_serial_rx_multi
//   Oversampling receiver for the mbed one-wire link. Decodes frames of
//   start(1) / address / data / optional even parity / stop(0) and writes
//   the data field into one of NUM_CH channel registers feeding the servo
//   drivers.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   mbed_pulse  raw serial line, idle low, asynchronous to clk
//   err_clr     synchronous clear of the sticky error flags
//   ch_data     flattened channel registers, channel k at [k*DATA_W +: DATA_W]
//   ch_update   one-cycle write strobe per channel
//   busy        receiver is inside a frame (not IDLE)
//   parity_err  sticky: parity mismatch seen
//   frame_err   sticky: stop bit was not 0
//   addr_err    sticky: address >= NUM_CH
module mbed_serial_rx_multi #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int RESET_VAL    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mbed_pulse,
  input  logic                     err_clr,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_update,
  output logic                     busy,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     addr_err
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] SHIFT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [ADDR_W:0]  NUM_CH_L   = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHIFT, S_PARITY, S_STOP, S_COMMIT
  } state_t;

  state_t             state, state_nxt;
  logic               sync_ff1, sync_in;
  logic [CNT_W-1:0]   timer;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic               par_bit, stop_bit;
  logic               half_tick, bit_tick;
  logic [ADDR_W-1:0]  frm_addr;
  logic [DATA_W-1:0]  frm_data;
  logic               par_ok, addr_ok, stop_ok, frame_good;

  assign half_tick = (timer == HALF_LAST);
  assign bit_tick  = (timer == BIT_LAST);
  assign busy      = (state != S_IDLE);

  assign frm_addr   = shreg[FRAME_W-1 -: ADDR_W];
  assign frm_data   = shreg[DATA_W-1:0];
  // Even parity: the received parity bit must equal the XOR of addr+data.
  assign par_ok     = (PARITY_EN == 0) || ((^shreg) == par_bit);
  assign addr_ok    = ({1'b0, frm_addr} < NUM_CH_L);
  assign stop_ok    = !stop_bit;
  assign frame_good = par_ok && addr_ok && stop_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= 1'b0;
      sync_in  <= 1'b0;
    end else begin
      sync_ff1 <= mbed_pulse;
      sync_in  <= sync_ff1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sync_in) state_nxt = S_START;
      S_START:  if (half_tick) state_nxt = sync_in ? S_SHIFT : S_IDLE;
      S_SHIFT:  if (bit_tick && (bit_cnt == SHIFT_LAST))
                  state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_tick) state_nxt = S_STOP;
      S_STOP:   if (bit_tick) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The bit timer restarts on every state change, so after the half-bit wait
  // in START each later sample lands one full bit period later (mid-bit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
    end else begin
      if ((state_nxt != state) || bit_tick) timer <= '0;
      else if (state != S_IDLE)             timer <= timer + CNT_W'(1);

      if (state == S_START)                 bit_cnt <= '0;
      else if (state == S_SHIFT && bit_tick) bit_cnt <= bit_cnt + BIT_W'(1);

      if (state == S_SHIFT && bit_tick)  shreg    <= {shreg[FRAME_W-2:0], sync_in};
      if (state == S_PARITY && bit_tick) par_bit  <= sync_in;
      if (state == S_STOP && bit_tick)   stop_bit <= sync_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_data    <= {NUM_CH{DATA_W'(RESET_VAL)}};
      ch_update  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      ch_update <= '0;
      if (state == S_COMMIT && frame_good) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (frm_addr == ADDR_W'(k)) begin
            ch_data[k*DATA_W +: DATA_W] <= frm_data;
            ch_update[k]                <= 1'b1;
          end
        end
      end
      // Clear first, then set, so a new error in the clear cycle survives.
      if (err_clr) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        addr_err   <= 1'b0;
      end
      if (state == S_COMMIT) begin
        if (!par_ok)  parity_err <= 1'b1;
        if (!stop_ok) frame_err  <= 1'b1;
        if (!addr_ok) addr_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mbed_serial_rx_multi.sv
// Testbench for mbed_serial_rx_multi: three instances (default parameters,
// NUM_CH=3 with non-zero reset value, and a 12-bit/no-parity/8x variant)
// checked against a frame-level reference model.
module tb_mbed_serial_rx_multi;
  localparam int NI = 3;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          err_clr = 1'b0;
  logic          pulse [NI];
  logic [31:0]   d0, d1;
  logic [47:0]   d2;
  logic [3:0]    u0, u2;
  logic [2:0]    u1;
  logic [NI-1:0] busy, perr, ferr, aerr;
  logic [63:0]   flat [NI];
  logic [3:0]    upd  [NI];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int multi_hot = 0;

  typedef struct { int inst; int ch; int val; int cyc; } ev_t;
  ev_t evq[$];

  int exp_d [NI][4];
  bit exp_pe [NI];
  bit exp_fe [NI];
  bit exp_ae [NI];

  mbed_serial_rx_multi dut_a (
    .clk(clk), .rst_n(rst_n), .mbed_pulse(pulse[0]), .err_clr(err_clr),
    .ch_data(d0), .ch_update(u0), .busy(busy[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .addr_err(aerr[0]));

  mbed_serial_rx_multi #(.NUM_CH(3), .RESET_VAL('h5A)) dut_b (
    .clk(clk), .rst_n(rst_n), .mbed_pulse(pulse[1]), .err_clr(err_clr),
    .ch_data(d1[23:0]), .ch_update(u1), .busy(busy[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .addr_err(aerr[1]));
  assign d1[31:24] = 8'h00;

  mbed_serial_rx_multi #(.DATA_W(12), .CLKS_PER_BIT(8), .PARITY_EN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .mbed_pulse(pulse[2]), .err_clr(err_clr),
    .ch_data(d2), .ch_update(u2), .busy(busy[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .addr_err(aerr[2]));

  assign flat[0] = {32'h0, d0};
  assign flat[1] = {32'h0, d1};
  assign flat[2] = {16'h0, d2};
  assign upd[0]  = u0;
  assign upd[1]  = {1'b0, u1};
  assign upd[2]  = u2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // Per-instance parameters as seen by the model
  function automatic int p_nch(int i); return (i == 1) ? 3 : 4; endfunction
  function automatic int p_dw(int i);  return (i == 2) ? 12 : 8; endfunction
  function automatic int p_cpb(int i); return (i == 2) ? 8 : 4; endfunction
  function automatic int p_pen(int i); return (i == 2) ? 0 : 1; endfunction
  function automatic int p_rst(int i); return (i == 1) ? 'h5A : 0; endfunction

  function automatic int exp_lat(int i);
    return 2 + (1 + 2 + p_dw(i) + p_pen(i) + 1) * p_cpb(i) - p_cpb(i) / 2 + 1;
  endfunction

  function automatic logic [31:0] get_ch(int i, int c);
    logic [63:0] v;
    v = flat[i] >> (c * p_dw(i));
    return 32'(v & ((64'd1 << p_dw(i)) - 64'd1));
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if ($countones(upd[i]) > 1) multi_hot <= multi_hot + 1;
      for (int c = 0; c < p_nch(i); c++)
        if (upd[i][c] === 1'b1)
          evq.push_back('{inst: i, ch: c, val: int'(get_ch(i, c)), cyc: cyc});
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 4; c++) exp_d[i][c] = p_rst(i);
      exp_pe[i] = 1'b0; exp_fe[i] = 1'b0; exp_ae[i] = 1'b0;
    end
  endfunction

  function automatic void model_clr();
    for (int i = 0; i < NI; i++) begin
      exp_pe[i] = 1'b0; exp_fe[i] = 1'b0; exp_ae[i] = 1'b0;
    end
  endfunction

  // Returns 1 when the frame should be written to a channel.
  function automatic bit model_frame(int i, int a, int d, bit bad_par, bit stop_v);
    bit par_ok, good;
    par_ok = !(p_pen(i) != 0 && bad_par);
    good   = !stop_v && par_ok && (a < p_nch(i));
    if (good) exp_d[i][a] = d;
    else begin
      if (!par_ok)       exp_pe[i] = 1'b1;
      if (stop_v)        exp_fe[i] = 1'b1;
      if (a >= p_nch(i)) exp_ae[i] = 1'b1;
    end
    return good;
  endfunction

  // Called at a negedge; drives up to nbits line bits, returns on a negedge.
  task automatic drive_frame(input int i, input int a, input int d, input bit bad_par,
                             input bit stop_v, input int nbits, output int t0);
    bit bits[$];
    bits.push_back(1'b1);
    for (int k = 1; k >= 0; k--) bits.push_back(bit'((a >> k) & 1));
    for (int k = p_dw(i) - 1; k >= 0; k--) bits.push_back(bit'((d >> k) & 1));
    if (p_pen(i) != 0)
      bits.push_back(bit'((($countones(a) + $countones(d)) % 2) ^ int'(bad_par)));
    bits.push_back(stop_v);
    t0 = cyc;
    for (int b = 0; b < bits.size() && b < nbits; b++) begin
      pulse[i] = bits[b];
      repeat (p_cpb(i)) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < NI; i++) pulse[i] = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < p_nch(i); c++) begin
        checks++;
        if (get_ch(i, c) !== 32'(exp_d[i][c])) begin
          errors++;
          $display("FAIL reset_data inst%0d ch%0d: got %h expected %h", i, c, get_ch(i, c), exp_d[i][c]);
        end
      end
      checks++;
      if ({busy[i], perr[i], ferr[i], aerr[i], upd[i]} !== 8'h00) begin
        errors++;
        $display("FAIL reset_ctrl inst%0d: got busy/pe/fe/ae/upd=%b expected 0", i,
                 {busy[i], perr[i], ferr[i], aerr[i], upd[i]});
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int t0;
    bit good;
    evq.delete();
    drive_frame(0, 2, 'hA5, 1'b0, 1'b0, 99, t0);
    pulse[0] = 1'b0;
    repeat (12) @(negedge clk);
    good = model_frame(0, 2, 'hA5, 1'b0, 1'b0);
    checks++;
    if (evq.size() != int'(good)) begin
      errors++;
      $display("FAIL good_strobes: got %0d strobes expected %0d", evq.size(), good);
    end else begin
      checks++;
      if (evq[0].ch != 2 || evq[0].val != 'hA5) begin
        errors++;
        $display("FAIL good_strobe: got ch%0d=%h expected ch2=a5", evq[0].ch, evq[0].val);
      end
      checks++;
      if (evq[0].cyc - (t0 + 1) < exp_lat(0) - 1 || evq[0].cyc - (t0 + 1) > exp_lat(0) + 1) begin
        errors++;
        $display("FAIL good_latency: got %0d expected %0d+-1", evq[0].cyc - (t0 + 1), exp_lat(0));
      end
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (get_ch(0, c) !== 32'(exp_d[0][c])) begin
        errors++;
        $display("FAIL good_data ch%0d: got %h expected %h", c, get_ch(0, c), exp_d[0][c]);
      end
    end
    checks++;
    if ({perr[0], ferr[0], aerr[0], busy[0]} !== 4'b0000) begin
      errors++;
      $display("FAIL good_flags: got pe/fe/ae/busy=%b expected 0000", {perr[0], ferr[0], aerr[0], busy[0]});
    end
  endtask

  task automatic test_parity_err();
    int t0;
    bit good;
    evq.delete();
    drive_frame(0, 2, 'hA5, 1'b1, 1'b0, 99, t0);
    pulse[0] = 1'b0;
    repeat (12) @(negedge clk);
    good = model_frame(0, 2, 'hA5, 1'b1, 1'b0);
    checks++;
    if (evq.size() != int'(good)) begin
      errors++;
      $display("FAIL parity_strobes: got %0d expected %0d", evq.size(), good);
    end
    checks++;
    if ({perr[0], ferr[0], aerr[0]} !== {exp_pe[0], exp_fe[0], exp_ae[0]}) begin
      errors++;
      $display("FAIL parity_flags: got %b expected %b", {perr[0], ferr[0], aerr[0]},
               {exp_pe[0], exp_fe[0], exp_ae[0]});
    end
    checks++;
    if (get_ch(0, 2) !== 32'(exp_d[0][2])) begin
      errors++;
      $display("FAIL parity_data: got %h expected %h", get_ch(0, 2), exp_d[0][2]);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_clr();
    @(negedge clk);
    checks++;
    if (perr[0] !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear: got %b expected 0", perr[0]);
    end
  endtask

  task automatic test_framing_glitch();
    int t0;
    bit good;
    evq.delete();
    drive_frame(0, 1, 'h3E, 1'b0, 1'b1, 99, t0);
    pulse[0] = 1'b0;
    repeat (12) @(negedge clk);
    good = model_frame(0, 1, 'h3E, 1'b0, 1'b1);
    checks++;
    if (evq.size() != int'(good) || get_ch(0, 1) !== 32'(exp_d[0][1])) begin
      errors++;
      $display("FAIL frame_nowrite: got %0d strobes ch1=%h expected %0d strobes ch1=%h",
               evq.size(), get_ch(0, 1), good, exp_d[0][1]);
    end
    checks++;
    if ({perr[0], ferr[0], aerr[0]} !== {exp_pe[0], exp_fe[0], exp_ae[0]}) begin
      errors++;
      $display("FAIL frame_flags: got %b expected %b", {perr[0], ferr[0], aerr[0]},
               {exp_pe[0], exp_fe[0], exp_ae[0]});
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_clr();
    // one-cycle glitch
    pulse[0] = 1'b1;
    @(negedge clk);
    pulse[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_seen: got busy=%b expected 1", busy[0]);
    end
    repeat (p_cpb(0) / 2 + 1) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || {perr[0], ferr[0], aerr[0]} !== 3'b000 || evq.size() != 0) begin
      errors++;
      $display("FAIL glitch_idle: got busy=%b flags=%b strobes=%0d expected 0 000 0",
               busy[0], {perr[0], ferr[0], aerr[0]}, evq.size());
    end
  endtask

  task automatic test_addr_range();
    int t0;
    bit good;
    evq.delete();
    drive_frame(1, 3, 'h99, 1'b0, 1'b0, 99, t0);
    pulse[1] = 1'b0;
    repeat (12) @(negedge clk);
    good = model_frame(1, 3, 'h99, 1'b0, 1'b0);
    checks++;
    if (evq.size() != int'(good) || aerr[1] !== exp_ae[1]) begin
      errors++;
      $display("FAIL addr_err: got strobes=%0d addr_err=%b expected %0d %b",
               evq.size(), aerr[1], good, exp_ae[1]);
    end
    evq.delete();
    drive_frame(1, 0, 'h3C, 1'b0, 1'b0, 99, t0);
    pulse[1] = 1'b0;
    repeat (12) @(negedge clk);
    good = model_frame(1, 0, 'h3C, 1'b0, 1'b0);
    checks++;
    if (evq.size() != int'(good)) begin
      errors++;
      $display("FAIL addr_ok_strobes: got %0d expected %0d", evq.size(), good);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (get_ch(1, c) !== 32'(exp_d[1][c])) begin
        errors++;
        $display("FAIL addr_data ch%0d: got %h expected %h", c, get_ch(1, c), exp_d[1][c]);
      end
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_clr();
  endtask

  task automatic test_reset_mid();
    int t0;
    evq.delete();
    drive_frame(0, 1, 'h77, 1'b0, 1'b0, 5, t0);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: got %b expected 1", busy[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < p_nch(i); c++) begin
        checks++;
        if (get_ch(i, c) !== 32'(exp_d[i][c])) begin
          errors++;
          $display("FAIL rstmid_data inst%0d ch%0d: got %h expected %h", i, c, get_ch(i, c), exp_d[i][c]);
        end
      end
      checks++;
      if ({busy[i], perr[i], ferr[i], aerr[i], upd[i]} !== 8'h00) begin
        errors++;
        $display("FAIL rstmid_ctrl inst%0d: got %b expected 0", i, {busy[i], perr[i], ferr[i], aerr[i], upd[i]});
      end
    end
    pulse[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (evq.size() != 0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: got strobes=%0d busy=%b expected 0 0", evq.size(), busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    int t0 [3];
    int chs [3];
    int dat [3];
    chs = '{0, 1, 3};
    dat = '{'h11, 'h22, 'h33};
    evq.delete();
    for (int f = 0; f < 3; f++) drive_frame(0, chs[f], dat[f], 1'b0, 1'b0, 99, t0[f]);
    pulse[0] = 1'b0;
    repeat (12) @(negedge clk);
    for (int f = 0; f < 3; f++) void'(model_frame(0, chs[f], dat[f], 1'b0, 1'b0));
    checks++;
    if (evq.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes expected 3", evq.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        checks++;
        if (evq[f].ch != chs[f] || evq[f].val != dat[f] ||
            evq[f].cyc - (t0[f] + 1) < exp_lat(0) - 1 || evq[f].cyc - (t0[f] + 1) > exp_lat(0) + 1) begin
          errors++;
          $display("FAIL b2b_strobe%0d: got ch%0d=%h lat %0d expected ch%0d=%h lat %0d", f,
                   evq[f].ch, evq[f].val, evq[f].cyc - (t0[f] + 1), chs[f], dat[f], exp_lat(0));
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (get_ch(0, c) !== 32'(exp_d[0][c])) begin
        errors++;
        $display("FAIL b2b_data ch%0d: got %h expected %h", c, get_ch(0, c), exp_d[0][c]);
      end
    end
  endtask

  task automatic test_sweep();
    int t0;
    bit good;
    evq.delete();
    drive_frame(2, 1, 'hABC, 1'b0, 1'b0, 99, t0);
    pulse[2] = 1'b0;
    repeat (2 * p_cpb(2) + 4) @(negedge clk);
    good = model_frame(2, 1, 'hABC, 1'b0, 1'b0);
    checks++;
    if (evq.size() != int'(good)) begin
      errors++;
      $display("FAIL sweep_strobes: got %0d expected %0d", evq.size(), good);
    end else begin
      checks++;
      if (evq[0].cyc - (t0 + 1) < exp_lat(2) - 1 || evq[0].cyc - (t0 + 1) > exp_lat(2) + 1) begin
        errors++;
        $display("FAIL sweep_latency: got %0d expected %0d+-1", evq[0].cyc - (t0 + 1), exp_lat(2));
      end
    end
    checks++;
    if (get_ch(2, 1) !== 32'(exp_d[2][1]) || {perr[2], ferr[2], aerr[2]} !== 3'b000) begin
      errors++;
      $display("FAIL sweep_data: got ch1=%h flags=%b expected %h 000", get_ch(2, 1),
               {perr[2], ferr[2], aerr[2]}, exp_d[2][1]);
    end
  endtask

  task automatic test_random();
    int t0, i, a, d;
    bit bp, sv, good;
    for (int n = 0; n < 24; n++) begin
      i  = $urandom_range(0, NI - 1);
      a  = $urandom_range(0, 3);
      d  = $urandom_range(0, (1 << p_dw(i)) - 1);
      bp = ($urandom_range(0, 4) == 0);
      sv = ($urandom_range(0, 6) == 0);
      evq.delete();
      drive_frame(i, a, d, bp, sv, 99, t0);
      pulse[i] = 1'b0;
      repeat (2 * p_cpb(i) + 4) @(negedge clk);
      good = model_frame(i, a, d, bp, sv);
      checks++;
      if (evq.size() != int'(good) || (good && (evq[0].ch != a || evq[0].val != d))) begin
        errors++;
        $display("FAIL rand%0d_strobe inst%0d: got %0d strobes expected %0d (ch%0d=%h)",
                 n, i, evq.size(), good, a, d);
      end
      for (int c = 0; c < p_nch(i); c++) begin
        checks++;
        if (get_ch(i, c) !== 32'(exp_d[i][c])) begin
          errors++;
          $display("FAIL rand%0d_data inst%0d ch%0d: got %h expected %h", n, i, c, get_ch(i, c), exp_d[i][c]);
        end
      end
      checks++;
      if ({perr[i], ferr[i], aerr[i]} !== {exp_pe[i], exp_fe[i], exp_ae[i]}) begin
        errors++;
        $display("FAIL rand%0d_flags inst%0d: got %b expected %b", n, i,
                 {perr[i], ferr[i], aerr[i]}, {exp_pe[i], exp_fe[i], exp_ae[i]});
      end
      if ($urandom_range(0, 2) == 0) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_clr();
      end
    end
    checks++;
    if (multi_hot != 0) begin
      errors++;
      $display("FAIL one_hot: got %0d multi-bit strobe cycles expected 0", multi_hot);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) pulse[i] = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_parity_err();
    test_framing_glitch();
    test_addr_range();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mbed_serial_rx_multi.md
Name: mbed_serial_rx_multi

Overview:
Parametrised successor to the single-channel mbed pulse receiver. It takes the one-wire serial stream from the mbed, oversamples it, and decodes framed packets of the form start / address / data / optional parity / stop. Each decoded packet is written into one of NUM_CH per-channel data registers, with a one-cycle update strobe for that channel. It sits between the mbed link and the bank of servo drivers, one driver per channel.

Parameters:
NUM_CH, 4, number of output channels (1..2^ADDR_W).
ADDR_W, 2, width of the channel address field (>=1).
DATA_W, 8, width of the data field per channel (1..16).
CLKS_PER_BIT, 4, clk cycles per serial bit (>=4, even).
PARITY_EN, 1, 1 = even parity bit present after data; 0 = no parity bit.
RESET_VAL, 0, reset/initial value of every channel data register.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
mbed_pulse  in  1  raw serial line from mbed; idle low, asynchronous to clk.
err_clr  in  1  synchronous clear of the sticky error flags.
ch_data  out  NUM_CH*DATA_W  channel registers, flattened; channel k occupies [k*DATA_W +: DATA_W].
ch_update  out  NUM_CH  one-cycle strobe; bit k high when channel k is written.
busy  out  1  high whenever the FSM is not in IDLE.
parity_err  out  1  sticky flag; set on parity mismatch.
frame_err  out  1  sticky flag; set when the stop bit is not 0.
addr_err  out  1  sticky flag; set when the address is >= NUM_CH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; all counters are 0.
  - ch_data = RESET_VAL for every channel.
  - ch_update, busy and all three error flags = 0.
  - Synchroniser flops = 0.
  - Reset mid-frame abandons the frame; no channel is written.
- Input path:
  - mbed_pulse passes through a 2-flop synchroniser (sync_in); this adds 2 cycles of latency.
  - Only sync_in is used downstream.
- Frame format, in bit order on the line:
  - start bit = 1;
  - ADDR_W address bits, MSB first;
  - DATA_W data bits, MSB first;
  - parity bit, present only if PARITY_EN;
  - stop bit = 0.
- Parity rule: even parity over the address and data bits, i.e. the total count of 1s in address + data + parity is even.
- FSM states:
  - IDLE: wait for sync_in = 1, then go to START with the bit-timer cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If sync_in = 1, go to SHIFT with the timer cleared. If sync_in = 0, treat it as a glitch: return to IDLE, set no flag.
  - SHIFT: sample sync_in every CLKS_PER_BIT cycles, i.e. at each mid-bit. Shift samples into an (ADDR_W+DATA_W)-bit shift register and count them. After the last sample, go to PARITY if PARITY_EN, else to STOP.
  - PARITY: take one mid-bit sample and store it, then go to STOP.
  - STOP: take one mid-bit sample, then go to COMMIT.
  - COMMIT: lasts exactly one cycle.
    - The frame is good only if the stop sample = 0, parity matches (or PARITY_EN = 0), and address < NUM_CH.
    - Good frame: write the data field to ch_data[address] and pulse ch_update[address] for that cycle.
    - Bad frame: leave ch_data unchanged, set every applicable error flag (more than one may set), and drive no ch_update.
    - Then go to IDLE.
- Latency: from the mbed_pulse rising edge at the start bit to ch_update is about 2 + (1 + ADDR_W + DATA_W + PARITY_EN + 1) × CLKS_PER_BIT − CLKS_PER_BIT/2 + 1 cycles. The bench checks this ±1 cycle.
- At most one ch_update bit is high in any cycle. Other channels hold their values.
- A new frame is accepted only from IDLE. A line held high after COMMIT is taken as the next start bit.
- err_clr clears all three sticky flags. If err_clr and a new error occur in the same cycle, the set wins.
- busy is high in START, SHIFT, PARITY, STOP and COMMIT.

Test Plan:
- Good frame, default parameters: send frame to channel 2 with data 0xA5, i.e. start 1, address 10, data 10100101, parity 1, stop 0. Require ch_data[23:16] = 0xA5, ch_update = 4'b0100 for exactly 1 cycle, all other channels = 0, and no error flags.
- Parity error: same frame with parity bit 0. Require parity_err = 1, ch_data unchanged, no ch_update. Pulse err_clr, then require parity_err = 0.
- Framing and glitch handling:
  - A frame whose stop bit = 1 must set frame_err and write nothing.
  - A 1-cycle high glitch on mbed_pulse must return the FSM to IDLE, set no flag, and return busy to 0 within CLKS_PER_BIT/2 + 4 cycles.
- Address range: with NUM_CH = 3, send address 3. Require addr_err = 1 and no write. Then send address 0 with data 0x3C and require ch_data[7:0] = 0x3C.
- Reset mid-operation and back-to-back frames:
  - Assert rst_n low during SHIFT of a frame to channel 1. Require all outputs at reset values and no ch_update afterwards.
  - Then send frames to channels 0, 1, 3 (data 0x11, 0x22, 0x33) with no idle gap. Require three ch_update strobes in order and all three values held.
- Parameter sweep: PARITY_EN = 0, DATA_W = 12, CLKS_PER_BIT = 8, data 0xABC to channel 1. Require ch_data[23:12] = 0xABC, no parity bit expected, and latency within the formula ±1.
